// File: rtl/prng_pkg.sv
// Shared types and the Galois step function for the burst PRNG.
// Holds the FSM state enum, the default 16-bit tap mask and the step model.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] TAPS_16 = 16'hB400;

    // Widest LFSR the step function supports.
    localparam int MAX_W = 64;

    // One Galois shift; narrower LFSRs pass zero-extended state and taps.
    function automatic logic [MAX_W-1:0] galois_step(
        input logic [MAX_W-1:0] s,
        input logic [MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/prng_lfsr_step.sv
// Combinational one-step Galois LFSR next-state.
// Ports: state_i (current state), next_o (state after one shift).
import prng_pkg::*;

module prng_lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_16
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = WIDTH'(galois_step(MAX_W'(state_i), MAX_W'(TAPS)));

endmodule

// File: rtl/prng_lfsr_burst.sv
// Galois-LFSR word generator: bursts of words on a valid/ready stream.
// Ports: clk, rst (async, active-low), en, start, burst_len, load_seed,
// seed, out_ready in; out_valid, out_data, busy, done out.
// Build option PRNG_WHITEN_EN: out_data = state ^ half-swapped state.
import prng_pkg::*;

module prng_lfsr_burst #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_16,
    parameter int               STEPS     = 16,
    parameter int               BURST_MAX = 256,
    localparam int              CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             load_seed,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [SW-1:0]    step_q, step_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] lfsr_nxt;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] word_inc;

    function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] s);
`ifdef PRNG_WHITEN_EN
        return s ^ {s[WIDTH/2-1:0], s[WIDTH-1:WIDTH/2]};
`else
        return s;
`endif
    endfunction

    prng_lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i (lfsr_q),
        .next_o  (lfsr_nxt)
    );

    // Zero length means one word; oversize requests saturate.
    always_comb begin
        len_eff = burst_len;
        if (burst_len == '0) begin
            len_eff = CNT_W'(1);
        end else if (burst_len > CNT_W'(BURST_MAX)) begin
            len_eff = CNT_W'(BURST_MAX);
        end
    end

    assign word_inc = word_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        step_d  = step_q;
        word_d  = word_q;
        len_d   = len_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = done_q;
        // en low holds everything, done included.
        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_seed) begin
                        lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
                    end
                    if (start) begin
                        len_d   = len_eff;
                        step_d  = '0;
                        word_d  = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr_d = lfsr_nxt;
                    step_d = step_q + SW'(1);
                    if (step_q == SW'(STEPS - 1)) begin
                        data_d  = shape(lfsr_nxt);
                        valid_d = 1'b1;
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        word_d  = word_inc;
                        valid_d = 1'b0;
                        if (word_inc == len_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            step_d  = '0;
                            state_d = SHIFT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= WIDTH'(1);
            step_q  <= '0;
            word_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            step_q  <= step_d;
            word_q  <= word_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_prng_lfsr_burst.sv
// Scoreboard bench for prng_lfsr_burst (STEPS=1, 16-bit, BURST_MAX=256).
// Stimulus queues expected words; a negedge monitor checks handshakes.
import prng_pkg::*;

module tb_prng_lfsr_burst;

    localparam int          W     = 16;
    localparam logic [15:0] TP    = 16'hB400;
    localparam int          STP   = 1;
    localparam int          BMAX  = 256;
    localparam int          CW    = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          load_seed = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_exp = 0;
    logic hs_prev = 1'b0;
    logic [W-1:0] model_s = 16'h0001;
    logic [W-1:0] exp_q[$];

    prng_lfsr_burst #(
        .WIDTH     (W),
        .TAPS      (TP),
        .STEPS     (STP),
        .BURST_MAX (BMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .burst_len (burst_len),
        .load_seed (load_seed),
        .seed      (seed),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] wh(input logic [W-1:0] s);
`ifdef PRNG_WHITEN_EN
        return s ^ {s[7:0], s[15:8]};
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            hs_prev <= 1'b0;
        end else if (en) begin
            if (done) begin
                checks++;
                if (!hs_prev || busy) begin
                    errors++;
                    $display("FAIL done_timing: hs_prev=%0b busy=%0b need 1/0",
                             hs_prev, busy);
                end
                done_cnt++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word: got 0x%0h expected none", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL word: got 0x%0h expected 0x%0h",
                                 out_data, e);
                    end
                end
            end
            hs_prev <= out_valid && out_ready;
        end
    end

    task automatic push_hand(input logic [W-1:0] raw);
        model_s = raw;
        exp_q.push_back(wh(raw));
    endtask

    task automatic push_model(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < STP; j++) begin
                model_s = W'(galois_step(64'(model_s), 64'(TP)));
            end
            exp_q.push_back(wh(model_s));
        end
    endtask

    // Issues start; the caller queues the expected words.
    task automatic start_burst(input logic ld, input logic [W-1:0] sd,
                               input int len);
        if (ld) model_s = (sd == '0) ? 16'h0001 : sd;
        start     = 1'b1;
        load_seed = ld;
        seed      = sd;
        burst_len = CW'(len);
        done_exp++;
        tick();
        start     = 1'b0;
        load_seed = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL %s: out_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt != done_exp && n < budget) begin
            tick();
            n++;
        end
        check(name, done_cnt, done_exp);
        tick();
    endtask

    task automatic latency(input string name, input int stall, input int exp);
        int cyc = 1;
        if (stall > 0) begin
            en = 1'b0;
            repeat (stall) tick();
            cyc += stall;
            en = 1'b1;
        end
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check(name, cyc, exp);
    endtask

    initial begin
        // Reset
        repeat (5) tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_data", int'(out_data), 0);
        rst = 1'b1;
        tick();

        // Seed 1, one word: raw 0xB400
        out_ready = 1'b1;
        push_hand(16'hB400);
        start_burst(1'b1, 16'h0001, 1);
        latency("latency", 0, STP + 1);
        wait_done("done_single", 20);

        // Zero seed acts as 1; length 0 acts as 1
        push_hand(16'hB400);
        start_burst(1'b1, 16'h0000, 0);
        wait_done("done_zero_seed", 20);

        // Backpressure: 3 words, stall 10 cycles on word 2
        push_hand(16'h5A00);
        push_hand(16'h2D00);
        push_hand(16'h1680);
        out_ready = 1'b0;
        start_burst(1'b0, '0, 3);
        wait_valid("bp_w1");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("bp_w2");
        repeat (10) tick();
        out_ready = 1'b1;
        wait_done("done_backpressure", 50);

        // en low 5 cycles mid-SHIFT
        push_hand(16'h0B40);
        start_burst(1'b0, '0, 1);
        latency("latency_en_stall", 5, STP + 1 + 5);
        wait_done("done_en_stall", 20);

        // start + load_seed while busy are ignored
        push_model(4);
        start_burst(1'b0, '0, 4);
        tick();
        start     = 1'b1;
        load_seed = 1'b1;
        seed      = 16'h1234;
        burst_len = CW'(1);
        tick();
        start     = 1'b0;
        load_seed = 1'b0;
        wait_done("done_busy_ignore", 50);

        // Reset mid-burst: abort, no done
        push_model(5);
        start_burst(1'b0, '0, 5);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(out_valid), 0);
        exp_q.delete();
        done_exp--;
        model_s = 16'h0001;
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("midrst_no_done", done_cnt, done_exp);

        // Clamped burst (300 -> 256) from seed 0xACE1, ragged ready
        push_model(0);
        model_s = 16'hACE1;
        push_model(BMAX);
        start_burst(1'b1, 16'hACE1, 300);
        for (int k = 0; k < 3000 && done_cnt != done_exp; k++) begin
            out_ready = (k % 3 != 2);
            tick();
        end
        check("done_long", done_cnt, done_exp);
        out_ready = 1'b1;
        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
